sdram_init_seq: RTL and testbench

Parametrised SDRAM power-up and re-initialisation sequencer. It drives the command, bank and address buses through the JEDEC init sequence: power-up wait, precharge-all, N auto-refreshes, MRS, and an optional EMRS for mobile parts. It supports a runtime re-init handshake, for example after a self-refresh exit or a mode change. It sits ahead of the SDRAM arbiter, which owns the bus once `init_end` is high.

---
 rtl/sdram_pkg.sv | 38 +++
 rtl/sdram_init_timer.sv | 49 ++++
 rtl/sdram_init_seq.sv | 196 +++++++++++++++++++
 tb/tb_sdram_init_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// sdram_pkg: shared definitions for the SDRAM initialisation sequencer.
//   - SDRAM command encodings {CS#, RAS#, CAS#, WE#}
//   - sequencer state encoding
//   - ps2cyc(): picosecond time to clock cycles, rounded up, minimum 1
//   - mrs_field(): packs the 10-bit MRS mode word A9..A0
package sdram_pkg;

   localparam logic [3:0] CMD_NOP = 4'b0111;
   localparam logic [3:0] CMD_PRE = 4'b0010;
   localparam logic [3:0] CMD_AR  = 4'b0001;
   localparam logic [3:0] CMD_MRS = 4'b0000;

   localparam logic [3:0] ST_POWERUP = 4'd0;
   localparam logic [3:0] ST_PRE     = 4'd1;
   localparam logic [3:0] ST_TRP     = 4'd2;
   localparam logic [3:0] ST_AR      = 4'd3;
   localparam logic [3:0] ST_TRFC    = 4'd4;
   localparam logic [3:0] ST_MRS     = 4'd5;
   localparam logic [3:0] ST_TMRD    = 4'd6;
   localparam logic [3:0] ST_EMRS    = 4'd7;
   localparam logic [3:0] ST_DONE    = 4'd8;

   function automatic int ps2cyc(input int ps, input int period);
      int cyc;
      cyc = (ps + period - 32'sd1) / period;
      return (cyc < 32'sd1) ? 32'sd1 : cyc;
   endfunction

   // A9 = write burst mode, A8..A7 = 0, A6..A4 = CAS latency,
   // A3 = burst type, A2..A0 = burst length
   function automatic logic [9:0] mrs_field(input logic       write_burst,
                                            input logic [2:0] cas_lat,
                                            input logic       burst_type,
                                            input logic [2:0] burst_len);
      return {write_burst, 2'b00, cas_lat, burst_type, burst_len};
   endfunction

endpackage

// File: rtl/sdram_init_timer.sv
// sdram_init_timer: loadable down-counter shared by every wait state.
//   init_clk, init_rst_n : clock, asynchronous active-low reset
//   load                 : asserted on the first cycle of a wait
//   load_val             : wait length minus one
//   done                 : high on the final cycle of the wait
// A wait of N cycles is loaded with N-1; the load cycle itself is the
// first waiting cycle, so load_val == 0 gives a single-cycle wait.
module sdram_init_timer #(
   parameter int W = 8
) (
   input  logic         init_clk,
   input  logic         init_rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   localparam logic [W-1:0] ZERO_C = W'(0);
   localparam logic [W-1:0] ONE_C  = W'(1);

   logic [W-1:0] cnt_r;

   // final-cycle flag; on the load cycle the fresh value decides
   always_comb begin
      if (load) begin
         done = (load_val == ZERO_C);
      end else begin
         done = (cnt_r == ZERO_C);
      end
   end

   // countdown register, holds at zero between waits
   always_ff @(posedge init_clk or negedge init_rst_n) begin
      if (!init_rst_n) begin
         cnt_r <= ZERO_C;
      end else if (load) begin
         if (load_val == ZERO_C) begin
            cnt_r <= ZERO_C;
         end else begin
            cnt_r <= load_val - ONE_C;
         end
      end else if (cnt_r != ZERO_C) begin
         cnt_r <= cnt_r - ONE_C;
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/sdram_init_seq.sv
// sdram_init_seq: SDRAM power-up / re-initialisation sequencer.
//   init_clk, init_rst_n : clock, asynchronous active-low reset
//   init_req             : re-init request level, honoured only when done
//   init_ack             : one-cycle pulse when a re-init is accepted
//   init_cmd             : {CS#, RAS#, CAS#, WE#}
//   init_bank, init_addr : bank and address buses
//   init_end             : sequence complete (level)
// Sequence: power-up wait, PRE-all, AR_COUNT auto-refreshes, MRS and an
// optional EMRS. All bus outputs are registered from the current state,
// so the bus trails the state by one cycle.
module sdram_init_seq
   import sdram_pkg::*;
#(
   parameter int               CLK_PERIOD_PS = 10000,
   parameter int               T_PU_PS       = 100_000_000,
   parameter int               TRP_PS        = 20000,
   parameter int               TRFC_PS       = 66000,
   parameter int               TMRD_CYC      = 2,
   parameter int               AR_COUNT      = 2,
   parameter int               ROW_W         = 13,
   parameter int               BANK_W        = 2,
   parameter logic [2:0]       CAS_LAT       = 3'b011,
   parameter logic             BURST_TYPE    = 1'b0,
   parameter logic [2:0]       BURST_LEN     = 3'b111,
   parameter logic             WRITE_BURST   = 1'b0,
   parameter bit               EMRS_EN       = 1'b0,
   parameter logic [ROW_W-1:0] EMRS_VAL      = '0
) (
   input  logic              init_clk,
   input  logic              init_rst_n,
   input  logic              init_req,
   output logic              init_ack,
   output logic [3:0]        init_cmd,
   output logic [BANK_W-1:0] init_bank,
   output logic [ROW_W-1:0]  init_addr,
   output logic              init_end
);

   localparam int PU_CYC   = ps2cyc(T_PU_PS, CLK_PERIOD_PS);
   localparam int TRP_CYC  = ps2cyc(TRP_PS, CLK_PERIOD_PS);
   localparam int TRFC_CYC = ps2cyc(TRFC_PS, CLK_PERIOD_PS);
   localparam int TW       = $clog2(PU_CYC) + 1;

   localparam logic [TW-1:0] PU_LD   = TW'(PU_CYC - 1);
   localparam logic [TW-1:0] TRP_LD  = TW'(TRP_CYC - 1);
   localparam logic [TW-1:0] TRFC_LD = TW'(TRFC_CYC - 1);
   localparam logic [TW-1:0] TMRD_LD = TW'(TMRD_CYC - 1);
   localparam logic [3:0]    AR_LAST = 4'(AR_COUNT);

   localparam logic [ROW_W-1:0] MRS_ADDR =
      {{(ROW_W-10){1'b0}}, mrs_field(WRITE_BURST, CAS_LAT, BURST_TYPE, BURST_LEN)};

   logic [3:0]        state_r;
   logic [3:0]        state_nx_s;
   logic              entry_r;
   logic [3:0]        ar_cnt_r;
   logic              emrs_done_r;
   logic              accept_s;
   logic              tmr_load_s;
   logic [TW-1:0]     tmr_val_s;
   logic              tmr_done_s;
   logic [3:0]        cmd_nx_s;
   logic [BANK_W-1:0] bank_nx_s;
   logic [ROW_W-1:0]  addr_nx_s;

   // re-init request is only looked at while parked in DONE
   always_comb begin
      accept_s = (state_r == ST_DONE) && init_req;
   end

   // wait timer is (re)loaded on the first cycle of each wait state;
   // entry_r marks that first cycle, including POWERUP straight out of reset
   always_comb begin
      tmr_val_s  = {TW{1'b0}};
      tmr_load_s = 1'b0;
      case (state_r)
         ST_POWERUP: begin tmr_val_s = PU_LD;   tmr_load_s = entry_r; end
         ST_TRP:     begin tmr_val_s = TRP_LD;  tmr_load_s = entry_r; end
         ST_TRFC:    begin tmr_val_s = TRFC_LD; tmr_load_s = entry_r; end
         ST_TMRD:    begin tmr_val_s = TMRD_LD; tmr_load_s = entry_r; end
         default:    begin tmr_val_s = {TW{1'b0}}; tmr_load_s = 1'b0; end
      endcase
   end

   sdram_init_timer #(
      .W(TW)
   ) u_timer (
      .init_clk   (init_clk),
      .init_rst_n (init_rst_n),
      .load       (tmr_load_s),
      .load_val   (tmr_val_s),
      .done       (tmr_done_s)
   );

   // next-state logic
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_POWERUP: begin
            if (tmr_done_s) state_nx_s = ST_PRE;
            else            state_nx_s = ST_POWERUP;
         end
         ST_PRE:  state_nx_s = ST_TRP;
         ST_TRP: begin
            if (tmr_done_s) state_nx_s = ST_AR;
            else            state_nx_s = ST_TRP;
         end
         ST_AR:   state_nx_s = ST_TRFC;
         ST_TRFC: begin
            // ar_cnt_r already counts the refresh just issued
            if (!tmr_done_s)              state_nx_s = ST_TRFC;
            else if (ar_cnt_r < AR_LAST)  state_nx_s = ST_AR;
            else                          state_nx_s = ST_MRS;
         end
         ST_MRS:  state_nx_s = ST_TMRD;
         ST_TMRD: begin
            if (!tmr_done_s)                  state_nx_s = ST_TMRD;
            else if (EMRS_EN && !emrs_done_r) state_nx_s = ST_EMRS;
            else                              state_nx_s = ST_DONE;
         end
         ST_EMRS: state_nx_s = ST_TMRD;
         ST_DONE: begin
            if (accept_s) state_nx_s = ST_PRE;
            else          state_nx_s = ST_DONE;
         end
         default: state_nx_s = ST_POWERUP;
      endcase
   end

   // state, wait-entry marker, refresh count and EMRS-issued flag
   always_ff @(posedge init_clk or negedge init_rst_n) begin
      if (!init_rst_n) begin
         state_r     <= ST_POWERUP;
         entry_r     <= 1'b1;
         ar_cnt_r    <= 4'd0;
         emrs_done_r <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         entry_r <= (state_nx_s != state_r);
         if (state_nx_s == ST_PRE) begin
            ar_cnt_r    <= 4'd0;
            emrs_done_r <= 1'b0;
         end else begin
            if (state_r == ST_AR) ar_cnt_r <= ar_cnt_r + 4'd1;
            else                  ar_cnt_r <= ar_cnt_r;
            if (state_r == ST_EMRS) emrs_done_r <= 1'b1;
            else                    emrs_done_r <= emrs_done_r;
         end
      end
   end

   // bus decode of the current state; idle value is NOP with all-ones buses
   always_comb begin
      cmd_nx_s  = CMD_NOP;
      bank_nx_s = {BANK_W{1'b1}};
      addr_nx_s = {ROW_W{1'b1}};
      case (state_r)
         ST_PRE: cmd_nx_s = CMD_PRE;
         ST_AR:  cmd_nx_s = CMD_AR;
         ST_MRS: begin
            cmd_nx_s  = CMD_MRS;
            bank_nx_s = {BANK_W{1'b0}};
            addr_nx_s = MRS_ADDR;
         end
         ST_EMRS: begin
            cmd_nx_s     = CMD_MRS;
            bank_nx_s    = {BANK_W{1'b0}};
            bank_nx_s[1] = 1'b1;
            addr_nx_s    = EMRS_VAL;
         end
         default: begin
            cmd_nx_s  = CMD_NOP;
            bank_nx_s = {BANK_W{1'b1}};
            addr_nx_s = {ROW_W{1'b1}};
         end
      endcase
   end

   // registered outputs; init_end falls on the same edge init_ack rises
   always_ff @(posedge init_clk or negedge init_rst_n) begin
      if (!init_rst_n) begin
         init_cmd  <= CMD_NOP;
         init_bank <= {BANK_W{1'b1}};
         init_addr <= {ROW_W{1'b1}};
         init_end  <= 1'b0;
         init_ack  <= 1'b0;
      end else begin
         init_cmd  <= cmd_nx_s;
         init_bank <= bank_nx_s;
         init_addr <= addr_nx_s;
         init_end  <= (state_r == ST_DONE) && !accept_s;
         init_ack  <= accept_s;
      end
   end

endmodule

// File: tb/tb_sdram_init_seq.sv
// tb_sdram_init_seq: three sequencer instances (default timing, 4 refreshes
// with EMRS, 7.5 ns clock with 1-cycle tMRD and non-default mode word) are
// driven with random init_req holds. A reference model lays out the expected
// bus events (commands, init_end rise, init_ack) as absolute cycle numbers
// from the timing rules; a monitor per instance pops and compares them.
module tb_sdram_init_seq;

   typedef struct {
      int          kind;   // 0 = command, 1 = init_end rise, 2 = init_ack
      logic [3:0]  cmd;
      logic [1:0]  bank;
      logic [12:0] addr;
      int          at;
   } ev_t;

   logic clk;
   int   n_tests = 0;
   int   n_fail  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int cdiv(input int a, input int b);
      int c;
      c = (a + b - 1) / b;
      return (c < 1) ? 1 : c;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int          G     = g;
      localparam int          CLK_P = (g == 2) ? 7500 : 10000;
      localparam int          ARN   = (g == 1) ? 4 : 2;
      localparam bit          EM    = (g == 1);
      localparam logic [12:0] EMV   = (g == 1) ? 13'h020 : 13'h000;
      localparam int          TMRD  = (g == 2) ? 1 : 2;
      localparam logic [2:0]  CL    = (g == 2) ? 3'b010 : 3'b011;
      localparam logic        BT    = (g == 2) ? 1'b1 : 1'b0;
      localparam logic [2:0]  BL    = (g == 2) ? 3'b011 : 3'b111;
      localparam logic        WB    = (g == 2) ? 1'b1 : 1'b0;
      localparam int          PU    = cdiv(200000, CLK_P);
      localparam int          TRP   = cdiv(20000, CLK_P);
      localparam int          TRFC  = cdiv(66000, CLK_P);
      localparam logic [12:0] MRS_A =
         13'(int'(WB) * 512 + int'(CL) * 16 + int'(BT) * 8 + int'(BL));

      logic        rst_n_g, req_g, fin;
      logic [3:0]  cmd_w;
      logic [1:0]  bank_w;
      logic [12:0] addr_w;
      logic        end_w, ack_w;
      ev_t         q[$];
      int          done_at;
      int          n;
      int          k;
      int          hold;
      logic        lvl;

      sdram_init_seq #(
         .CLK_PERIOD_PS(CLK_P), .T_PU_PS(200000), .TRP_PS(20000),
         .TRFC_PS(66000), .TMRD_CYC(TMRD), .AR_COUNT(ARN), .ROW_W(13),
         .BANK_W(2), .CAS_LAT(CL), .BURST_TYPE(BT), .BURST_LEN(BL),
         .WRITE_BURST(WB), .EMRS_EN(EM), .EMRS_VAL(EMV)
      ) u_dut (
         .init_clk   (clk),
         .init_rst_n (rst_n_g),
         .init_req   (req_g),
         .init_ack   (ack_w),
         .init_cmd   (cmd_w),
         .init_bank  (bank_w),
         .init_addr  (addr_w),
         .init_end   (end_w)
      );

      task automatic push(input int kind, input logic [3:0] c, input logic [1:0] b,
                          input logic [12:0] a, input int at);
         ev_t e;
         e.kind = kind; e.cmd = c; e.bank = b; e.addr = a; e.at = at;
         q.push_back(e);
      endtask

      // expected command schedule for a sequence whose first state starts at 'start'
      task automatic sched(input int start, input bit with_pu);
         int s;
         s = start;
         if (with_pu) s += PU;
         push(0, 4'b0010, 2'b11, 13'h1FFF, s + 1);
         s += 1 + TRP;
         for (int i = 0; i < ARN; i++) begin
            push(0, 4'b0001, 2'b11, 13'h1FFF, s + 1);
            s += 1 + TRFC;
         end
         push(0, 4'b0000, 2'b00, MRS_A, s + 1);
         s += 1 + TMRD;
         if (EM) begin
            push(0, 4'b0000, 2'b10, EMV, s + 1);
            s += 1 + TMRD;
         end
         done_at = s;
      endtask

      // model reaction to the request level held during cycle kk
      task automatic step(input int kk, input logic r);
         if (kk >= done_at) begin
            if (r) begin
               push(2, 4'b0111, 2'b11, 13'h1FFF, kk + 1);
               sched(kk + 1, 1'b0);
            end else if (kk == done_at) begin
               push(1, 4'b0111, 2'b11, 13'h1FFF, kk + 1);
            end
         end
      endtask

      task automatic next_req();
         if (hold == 0) begin
            lvl  = ($urandom_range(9, 0) < 32'd4);
            hold = $urandom_range(40, 1);
         end
         hold--;
         req_g = lvl;
      endtask

      task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
         n_tests++;
         if (act !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s got %h required %h", G, name, act, exp);
         end
      endtask

      task automatic chk_reset_vals();
         chk_val("reset_cmd",  32'(cmd_w),  32'h7);
         chk_val("reset_bank", 32'(bank_w), 32'h3);
         chk_val("reset_addr", 32'(addr_w), 32'h1FFF);
         chk_val("reset_end",  32'(end_w),  32'h0);
         chk_val("reset_ack",  32'(ack_w),  32'h0);
      endtask

      task automatic chk_ev(input int kind);
         ev_t e;
         n_tests++;
         if (q.size() == 0 || q[0].at != n) begin
            n_fail++;
            $display("FAIL dut%0d unexpected_event kind=%0d cmd=%b at cycle %0d, required none (next expected at %0d)",
                     G, kind, cmd_w, n, (q.size() > 0) ? q[0].at : -1);
         end else begin
            e = q.pop_front();
            if (e.kind != kind || e.cmd !== cmd_w || e.bank !== bank_w || e.addr !== addr_w) begin
               n_fail++;
               $display("FAIL dut%0d event@%0d got kind=%0d cmd=%b bank=%b addr=%h, required kind=%0d cmd=%b bank=%b addr=%h",
                        G, n, kind, cmd_w, bank_w, addr_w, e.kind, e.cmd, e.bank, e.addr);
            end
         end
      endtask

      // monitor: samples on the falling edge, cycle 0 is the first after release
      initial begin : mon
         logic prev_end;
         prev_end = 1'b0;
         n = 0;
         forever begin
            @(negedge clk);
            if (!rst_n_g) begin
               n = 0;
               prev_end = 1'b0;
            end else begin
               while (q.size() > 0 && q[0].at < n) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL dut%0d missed_event kind=%0d cmd=%b required at cycle %0d, absent at %0d",
                           G, q[0].kind, q[0].cmd, q[0].at, n);
                  void'(q.pop_front());
               end
               if (end_w && !prev_end) chk_ev(1);
               if (ack_w) begin
                  chk_ev(2);
                  chk_val("end_low_with_ack", 32'(end_w), 32'h0);
               end
               if (cmd_w !== 4'b0111) chk_ev(0);
               prev_end = end_w;
               n++;
            end
         end
      end

      // driver and reference model
      initial begin : drv
         int rst_k;
         fin = 1'b0; hold = 0; lvl = 1'b0; done_at = 0;
         rst_n_g = 1'b0; req_g = 1'b0;
         repeat (3) @(posedge clk);
         #1;
         chk_reset_vals();
         // first sequence, interrupted by reset on the bus cycle showing the second AR
         rst_n_g = 1'b1;
         sched(0, 1'b1);
         rst_k = PU + 1 + TRP + (1 + TRFC) + 1;
         k = 0;
         while (k < rst_k) begin
            next_req(); step(k, req_g);
            @(posedge clk); #1; k++;
         end
         chk_val("pre_reset_cmd_is_ar", 32'(cmd_w), 32'h1);
         rst_n_g = 1'b0;
         q.delete();
         #1;
         chk_reset_vals();
         repeat (2) @(posedge clk);
         #1;
         rst_n_g = 1'b1;
         sched(0, 1'b1);
         k = 0;
         // random request holds across power-up, sequences and DONE
         for (int c = 0; c < 1500; c++) begin
            next_req(); step(k, req_g);
            @(posedge clk); #1; k++;
         end
         req_g = 1'b0;
         for (int c = 0; c < 400 && k <= done_at + 2; c++) begin
            step(k, 1'b0);
            @(posedge clk); #1; k++;
         end
         chk_val("drain_queue_empty", 32'(q.size()), 32'h0);
         chk_val("final_init_end", 32'(end_w), 32'h1);
         fin = 1'b1;
      end
   end

   initial begin : summary
      bit all_fin;
      all_fin = 1'b0;
      for (int i = 0; i < 20000 && !all_fin; i++) begin
         @(posedge clk);
         all_fin = g_dut[0].fin && g_dut[1].fin && g_dut[2].fin;
      end
      if (!all_fin) begin
         n_tests++;
         n_fail++;
         $display("FAIL timeout drivers_finished=%b required 1", all_fin);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
